// File: rtl/mycpu_wb_stage.sv
// Write-back stage: holds one instruction from MEM, commits it to the register file, and drives the ID bypass and the commit trace.
// Optional retire counter is enabled by defining MYCPU_WB_RETIRE_CNT_EN; otherwise retire_cnt is tied to 0.
module mycpu_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ms_to_ws_valid,
    output logic             ws_allowin,
    input  logic [31:0]      ms_pc,
    input  logic [4:0]       ms_dest,
    input  logic [3:0]       ms_rf_we,
    input  logic [31:0]      ms_wdata,
    input  logic             trace_stall,
    input  logic             flush,
    output logic [3:0]       rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             ws_fwd_valid,
    output logic [4:0]       ws_fwd_dest,
    output logic [31:0]      ws_fwd_data,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_wen,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata,
    output logic [CNT_W-1:0] retire_cnt
);

    logic        ws_valid_reg;
    logic [31:0] pc_reg;
    logic [4:0]  dest_reg;
    logic [3:0]  we_reg;
    logic [31:0] wdata_reg;

    logic ws_ready_go;
    logic commit;
    logic dest_nz;

    assign ws_ready_go = ~trace_stall;
    assign ws_allowin  = ~ws_valid_reg | ws_ready_go;
    assign commit      = ws_valid_reg & ws_ready_go;
    assign dest_nz     = |dest_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_reg <= 1'b0;
            pc_reg       <= 32'd0;
            dest_reg     <= 5'd0;
            we_reg       <= 4'd0;
            wdata_reg    <= 32'd0;
        end else begin
            if (flush) begin
                ws_valid_reg <= 1'b0;
            end else if (ws_allowin) begin
                ws_valid_reg <= ms_to_ws_valid;
            end
            // Data follows the handshake alone; a flush only clears the valid flag.
            if (ms_to_ws_valid && ws_allowin) begin
                pc_reg    <= ms_pc;
                dest_reg  <= ms_dest;
                we_reg    <= ms_rf_we;
                wdata_reg <= ms_wdata;
            end
        end
    end

    // Writes to $zero are suppressed byte by byte along with non-commit cycles.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_we
            assign rf_we[gi] = we_reg[gi] & commit & dest_nz;
        end
    endgenerate

    assign rf_waddr = dest_reg;
    assign rf_wdata = wdata_reg;

    assign ws_fwd_valid = ws_valid_reg & (|we_reg) & dest_nz;
    assign ws_fwd_dest  = dest_reg;
    assign ws_fwd_data  = wdata_reg;

    assign debug_wb_pc       = pc_reg;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

`ifdef MYCPU_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_reg <= '0;
        end else if (commit) begin
            retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_cnt_reg;
`else
    assign retire_cnt = '0;
`endif

endmodule
